// File: rtl/io_pkg.sv
// Shared types and constants for the IO input controller (switch read path).
package io_pkg;

    localparam int DATA_W              = 32;
    localparam int SW_W                = 18;
    // 10 ms of stable key level at the 50 MHz board clock
    localparam int DEF_DEBOUNCE_CYCLES = 500000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        DONE         = 2'd3
    } io_state_e;

    // Keep the low sw_bits switches, zero everything above them.
    function automatic logic [DATA_W-1:0] zext_sw(input logic [SW_W-1:0] sw, input int sw_bits);
        logic [DATA_W-1:0] v;
        v = {DATA_W{1'b0}};
        for (int i = 0; i < SW_W; i++) begin
            if (i < sw_bits) begin
                v[i] = sw[i];
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/io_input_ctrl_key_debouncer.sv
// Two-flop synchroniser plus counter debouncer for the active-low confirm key.
// press_ev/release_ev are high in the cycle whose edge flips the debounced level.
module key_debouncer
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic deb,
    output logic press_ev,
    output logic release_ev
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             key_s_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             flip_s;

    // Bring the asynchronous pin into the clock domain; idle level is released (1).
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            key_s_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            key_s_q <= sync1_q;
        end
    end

    // Count consecutive cycles the synchronised level disagrees with the accepted level.
    always_comb begin
        flip_s = 1'b0;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        if (key_s_q == deb_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            flip_s = 1'b1;
            deb_d  = ~deb_q;
            cnt_d  = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounced level and stability counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            deb_q <= 1'b1;
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb        = deb_q;
    assign press_ev   = flip_s & deb_q;
    assign release_ev = flip_s & ~deb_q;

endmodule

// File: rtl/io_input_ctrl.sv
// IN-instruction service: stall the CPU, show live switches, wait for a debounced
// key press, latch the switches, and hand the value back on key release.
module io_input_ctrl
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SW_BITS         = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_req,
    input  logic              halt,
    input  logic              key_n,
    input  logic [SW_W-1:0]   SW,
    output logic [DATA_W-1:0] in_data,
    output logic              in_valid,
    output logic              stall,
    output logic              input_flag
);

    io_state_e         state_q;
    io_state_e         state_d;
    logic [DATA_W-1:0] in_data_q;
    logic [DATA_W-1:0] in_data_d;
    logic              press_ev_s;
    logic              release_ev_s;
    logic              abort_s;
    logic              key_deb_unused_s;  // level itself is not needed, only its edges

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .deb        (key_deb_unused_s),
        .press_ev   (press_ev_s),
        .release_ev (release_ev_s)
    );

    assign abort_s = halt | ~in_req;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an abort beats any key event in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_req && !halt) begin
                    state_d = WAIT_PRESS;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_PRESS: begin
                if (abort_s) begin
                    state_d = IDLE;
                end else if (press_ev_s) begin
                    state_d = WAIT_RELEASE;
                end else begin
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_RELEASE: begin
                if (abort_s) begin
                    state_d = IDLE;
                end else if (release_ev_s) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT_RELEASE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        stall      = 1'b0;
        input_flag = 1'b0;
        in_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                stall      = 1'b0;
                input_flag = 1'b0;
            end
            WAIT_PRESS, WAIT_RELEASE: begin
                stall      = 1'b1;
                input_flag = 1'b1;
            end
            DONE: begin
                in_valid = 1'b1;
            end
            default: begin
                stall      = 1'b0;
                input_flag = 1'b0;
                in_valid   = 1'b0;
            end
        endcase
    end

    // Capture switches on the accepted press; otherwise hold the last value.
    always_comb begin
        if ((state_q == WAIT_PRESS) && !abort_s && press_ev_s) begin
            in_data_d = zext_sw(SW, SW_BITS);
        end else begin
            in_data_d = in_data_q;
        end
    end

    // Data latch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_data_q <= {DATA_W{1'b0}};
        end else begin
            in_data_q <= in_data_d;
        end
    end

    assign in_data = in_data_q;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Self-checking bench for io_input_ctrl with DEBOUNCE_CYCLES=4, SW_BITS=4.
module tb_io_input_ctrl;

    localparam int DEB = 4;

    logic        clk;
    logic        reset;
    logic        in_req;
    logic        halt;
    logic        key_n;
    logic [17:0] SW;
    logic [31:0] in_data;
    logic        in_valid;
    logic        stall;
    logic        input_flag;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pin history, window of synchronised key samples, transaction flags
    logic        pin_hist[$];
    logic        ks_hist[$];
    logic        m_deb;
    bit          m_busy;
    bit          m_pressed;
    bit          m_done;
    logic [31:0] m_data;

    io_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .SW_BITS(4)) dut (
        .clk(clk), .reset(reset), .in_req(in_req), .halt(halt), .key_n(key_n),
        .SW(SW), .in_data(in_data), .in_valid(in_valid), .stall(stall), .input_flag(input_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one clock using the current inputs, then step the DUT.
    task automatic tick();
        logic ks;
        bit   flip;
        if (!reset) begin
            pin_hist.delete(); pin_hist.push_back(1'b1); pin_hist.push_back(1'b1);
            ks_hist.delete();
            m_deb = 1'b1; m_busy = 0; m_pressed = 0; m_done = 0; m_data = 32'd0;
        end else begin
            ks = pin_hist[0];  // pin value sampled two edges earlier
            ks_hist.push_back(ks);
            if (ks_hist.size() > DEB) void'(ks_hist.pop_front());
            flip = (ks_hist.size() == DEB);
            foreach (ks_hist[i]) if (ks_hist[i] == m_deb) flip = 0;
            if (m_done) m_done = 0;
            else if (!m_busy) begin m_busy = in_req && !halt; m_pressed = 0; end
            else if (halt || !in_req) m_busy = 0;
            else if (!m_pressed && flip && m_deb) begin m_pressed = 1; m_data = {28'd0, SW[3:0]}; end
            else if (m_pressed && flip && !m_deb) begin m_busy = 0; m_done = 1; end
            if (flip) begin m_deb = ~m_deb; ks_hist.delete(); end
            pin_hist.push_back(key_n);
            if (pin_hist.size() > 2) void'(pin_hist.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_req = 1'b0; halt = 1'b0; key_n = 1'b1; SW = 18'd0;
        repeat (3) tick();
        n_cmp++;
        if ({in_valid, stall, input_flag, in_data} !== 35'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", {in_valid, stall, input_flag, in_data});
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({in_valid, stall, input_flag} !== 3'b000) begin
            n_err++; $display("FAIL reset_idle: got %b expected 000", {in_valid, stall, input_flag});
        end
    endtask

    task automatic test_basic();
        int seen;
        SW = 18'h0000A; in_req = 1'b1;
        tick();
        n_cmp++;
        if ({stall, input_flag} !== 2'b11) begin
            n_err++; $display("FAIL basic_stall: got %b expected 11", {stall, input_flag});
        end
        key_n = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 5) begin
                n_cmp++;
                if (in_data !== 32'd0) begin n_err++; $display("FAIL basic_early: got %h expected 0", in_data); end
            end
            if (i == 6) begin
                n_cmp++;
                if (in_data !== 32'h0000000A) begin n_err++; $display("FAIL basic_latch: got %h expected a", in_data); end
            end
        end
        key_n = 1'b1; seen = 0;
        for (int i = 1; i <= 12 && seen == 0; i++) begin
            tick();
            if (in_valid === 1'b1) seen = i;
        end
        n_cmp++;
        if (seen != 6 || stall !== 1'b0 || in_data !== m_data) begin
            n_err++; $display("FAIL basic_valid: got cycle %0d stall %b data %h expected cycle 6 stall 0 data %h", seen, stall, in_data, m_data);
        end
        in_req = 1'b0;
        tick();
        n_cmp++;
        if ({in_valid, stall} !== 2'b00) begin n_err++; $display("FAIL basic_one_pulse: got %b expected 00", {in_valid, stall}); end
    endtask

    task automatic test_bounce();
        int bad;
        in_req = 1'b1; SW = 18'h00003;
        tick(); tick();
        bad = 0;
        for (int i = 0; i < 26; i++) begin
            key_n = (i < 18 && (i % 6) < 3) ? 1'b0 : 1'b1;
            tick();
            if ({in_valid, stall, input_flag} !== 3'b011 || in_data !== m_data) bad++;
        end
        n_cmp++;
        if (bad != 0 || in_data !== 32'h0000000A) begin
            n_err++; $display("FAIL bounce: got %0d bad cycles data %h expected 0 bad data a", bad, in_data);
        end
        in_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_preheld();
        int bad;
        int seen;
        SW = 18'h00007; key_n = 1'b0;
        repeat (10) tick();
        in_req = 1'b1; bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (in_data !== 32'h0000000A || stall !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL preheld_ignored: got %0d bad cycles expected 0", bad); end
        key_n = 1'b1;
        repeat (8) tick();
        n_cmp++;
        if (in_data !== 32'h0000000A || stall !== 1'b1) begin
            n_err++; $display("FAIL preheld_release: got data %h stall %b expected a 1", in_data, stall);
        end
        SW = 18'h00006; key_n = 1'b0;
        repeat (8) tick();
        n_cmp++;
        if (in_data !== 32'h00000006) begin n_err++; $display("FAIL preheld_repress: got %h expected 6", in_data); end
        key_n = 1'b1; seen = 0;
        for (int i = 1; i <= 12 && seen == 0; i++) begin tick(); if (in_valid === 1'b1) seen = i; end
        n_cmp++;
        if (seen != 6) begin n_err++; $display("FAIL preheld_valid: got cycle %0d expected 6", seen); end
        in_req = 1'b0;
        tick();
    endtask

    task automatic test_sw_change();
        int seen;
        SW = 18'h00005; in_req = 1'b1;
        tick();
        key_n = 1'b0;
        repeat (8) tick();
        SW = 18'h00009;
        repeat (4) tick();
        key_n = 1'b1; seen = 0;
        for (int i = 1; i <= 12 && seen == 0; i++) begin tick(); if (in_valid === 1'b1) seen = i; end
        n_cmp++;
        if (seen == 0 || in_data !== 32'h00000005) begin
            n_err++; $display("FAIL sw_change: got valid %0d data %h expected data 5", seen, in_data);
        end
        in_req = 1'b0;
        tick();
    endtask

    task automatic test_halt();
        int pulses;
        in_req = 1'b1;
        tick();
        halt = 1'b1;
        tick();
        n_cmp++;
        if ({in_valid, stall, input_flag} !== 3'b000) begin
            n_err++; $display("FAIL halt_abort: got %b expected 000", {in_valid, stall, input_flag});
        end
        halt = 1'b0; in_req = 1'b0; pulses = 0;
        repeat (4) begin tick(); if (in_valid === 1'b1) pulses++; end
        n_cmp++;
        if (pulses != 0) begin n_err++; $display("FAIL halt_no_valid: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        SW = 18'h00002; in_req = 1'b1;
        tick();
        key_n = 1'b0;
        repeat (8) tick();
        n_cmp++;
        if (in_data !== 32'h00000002 || stall !== 1'b1) begin
            n_err++; $display("FAIL rstmid_setup: got data %h stall %b expected 2 1", in_data, stall);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({in_valid, stall, input_flag, in_data} !== 35'd0) begin
            n_err++; $display("FAIL rstmid_clear: got %h expected 0", {in_valid, stall, input_flag, in_data});
        end
        reset = 1'b1; key_n = 1'b1; in_req = 1'b0; pulses = 0;
        repeat (10) begin tick(); if (in_valid === 1'b1) pulses++; end
        n_cmp++;
        if (pulses != 0) begin n_err++; $display("FAIL rstmid_no_valid: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_back_to_back();
        int seen;
        in_req = 1'b1; SW = 18'h00003;
        tick();
        key_n = 1'b0; repeat (8) tick();
        key_n = 1'b1; seen = 0;
        for (int i = 1; i <= 12 && seen == 0; i++) begin tick(); if (in_valid === 1'b1) seen = i; end
        n_cmp++;
        if (seen == 0 || in_data !== 32'h00000003) begin
            n_err++; $display("FAIL b2b_first: got valid %0d data %h expected data 3", seen, in_data);
        end
        SW = 18'h0000C;
        tick();
        n_cmp++;
        if ({in_valid, stall, input_flag} !== 3'b000) begin
            n_err++; $display("FAIL b2b_idle_gap: got %b expected 000", {in_valid, stall, input_flag});
        end
        tick();
        n_cmp++;
        if ({in_valid, stall, input_flag} !== 3'b011) begin
            n_err++; $display("FAIL b2b_restart: got %b expected 011", {in_valid, stall, input_flag});
        end
        key_n = 1'b0; repeat (8) tick();
        key_n = 1'b1; seen = 0;
        for (int i = 1; i <= 12 && seen == 0; i++) begin tick(); if (in_valid === 1'b1) seen = i; end
        n_cmp++;
        if (seen == 0 || in_data !== 32'h0000000C) begin
            n_err++; $display("FAIL b2b_second: got valid %0d data %h expected data c", seen, in_data);
        end
        in_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int run;
        int bad;
        logic [34:0] got;
        logic [34:0] exp;
        run = 3; bad = 0;
        for (int c = 0; c < 1500; c++) begin
            if (run == 0) begin key_n = ~key_n; run = $urandom_range(1, 8); end
            else run--;
            if (in_valid === 1'b1) in_req = 1'b0;
            else if (!in_req && $urandom_range(0, 7) == 0) in_req = 1'b1;
            else if (in_req && $urandom_range(0, 99) == 0) in_req = 1'b0;
            halt  = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 399) != 0);
            if ((c % 16) == 0) SW = 18'($urandom);
            tick();
            got = {in_valid, stall, input_flag, in_data};
            exp = {m_done, m_busy, m_busy, m_data};
            n_cmp++;
            if (got !== exp) begin
                n_err++; bad++;
                if (bad <= 10) $display("FAIL random_cycle%0d: got %h expected %h", c, got, exp);
            end
        end
        reset = 1'b1; halt = 1'b0; in_req = 1'b0; key_n = 1'b1;
    endtask

    initial begin
        reset = 1'b0; in_req = 1'b0; halt = 1'b0; key_n = 1'b1; SW = 18'd0;
        test_reset();
        test_basic();
        test_bounce();
        test_preheld();
        test_sw_change();
        test_halt();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
